// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes, FSM state encoding and flag bundle for the exception controller.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;
  localparam logic [4:0] EXC_NONE = 5'h1f;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    BA_ZERO = 2'd0,
    BA_PC   = 2'd1,
    BA_ADDR = 2'd2
  } badaddr_sel_e;

  typedef struct packed {
    logic adel;
    logic ri;
    logic ov;
    logic sys;
    logic bp;
    logic eret;
    logic ld_adel;
    logic st_ades;
  } exc_flags_t;

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// Combinational priority encoder: picks the highest-priority pending exception source.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic         int_pend_i,
  input  exc_flags_t   flags_i,
  output logic         hit_o,
  output logic [4:0]   code_o,
  output badaddr_sel_e badaddr_sel_o,
  output logic         is_eret_o
);

  always_comb begin
    hit_o         = 1'b1;
    code_o        = EXC_NONE;
    badaddr_sel_o = BA_ZERO;
    is_eret_o     = 1'b0;
    if (int_pend_i) begin
      code_o = EXC_INT;
    end else if (flags_i.adel) begin
      code_o        = EXC_ADEL;
      badaddr_sel_o = BA_PC;
    end else if (flags_i.ri) begin
      code_o = EXC_RI;
    end else if (flags_i.ov) begin
      code_o = EXC_OV;
    end else if (flags_i.sys) begin
      code_o = EXC_SYS;
    end else if (flags_i.bp) begin
      code_o = EXC_BP;
    end else if (flags_i.eret) begin
      code_o    = EXC_ERET;
      is_eret_o = 1'b1;
    end else if (flags_i.ld_adel) begin
      code_o        = EXC_ADEL;
      badaddr_sel_o = BA_ADDR;
    end else if (flags_i.st_ades) begin
      code_o        = EXC_ADES;
      badaddr_sel_o = BA_ADDR;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception arbiter between MEM and CP0: one-cycle exception pulse to CP0, pipeline flush
// and fetch redirect to the exception vector (or EPC on eret).
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_ds,
  input  logic [31:0] mem_addr,
  input  logic        f_adel,
  input  logic        f_ri,
  input  logic        f_ov,
  input  logic        f_sys,
  input  logic        f_bp,
  input  logic        f_eret,
  input  logic        f_ld_adel,
  input  logic        f_st_ades,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic [4:0]  exc_code,
  output logic [31:0] bad_addr,
  output logic        delay_slot,
  output logic [31:0] exc_pc,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output state_e      dbg_state
);

  localparam int CW = $clog2(FLUSH_CYCLES) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      code_q, code_d;
  logic [31:0]     bad_addr_q, bad_addr_d;
  logic            ds_q, ds_d;
  logic [31:0]     pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            redirect_q, redirect_d;
  logic [31:0]     rpc_q, rpc_d;

  logic            int_pend;
  exc_flags_t      flags;
  logic            hit;
  logic [4:0]      enc_code;
  badaddr_sel_e    enc_sel;
  logic            enc_eret;
  logic            take;

  logic            unused_ok;
  assign unused_ok = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

  assign int_pend = !cp0_status[1] & cp0_status[0] & |(cp0_status[15:8] & cp0_cause[15:8]);
  assign flags    = '{adel: f_adel, ri: f_ri, ov: f_ov, sys: f_sys, bp: f_bp,
                      eret: f_eret, ld_adel: f_ld_adel, st_ades: f_st_ades};

  exc_prio_enc u_prio (
    .int_pend_i    (int_pend),
    .flags_i       (flags),
    .hit_o         (hit),
    .code_o        (enc_code),
    .badaddr_sel_o (enc_sel),
    .is_eret_o     (enc_eret)
  );

  // Only IDLE can accept; anything seen during FLUSH belongs to a squashed instruction.
  assign take = (state_q == IDLE) & mem_valid & !stall & hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    bad_addr_d = bad_addr_q;
    ds_d       = ds_q;
    pc_d       = pc_q;
    flush_d    = flush_q;
    redirect_d = redirect_q;
    rpc_d      = rpc_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          code_d     = enc_code;
          ds_d       = mem_ds;
          pc_d       = mem_pc;
          flush_d    = 1'b1;
          redirect_d = 1'b1;
          cnt_d      = CW'(FLUSH_CYCLES - 1);
          state_d    = FLUSH;
          rpc_d      = enc_eret ? cp0_epc : EXC_VECTOR;
          case (enc_sel)
            BA_PC:   bad_addr_d = mem_pc;
            BA_ADDR: bad_addr_d = mem_addr;
            default: bad_addr_d = 32'h0;
          endcase
        end
      end
      FLUSH: begin
        code_d     = EXC_NONE;
        redirect_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          flush_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= EXC_NONE;
      bad_addr_q <= 32'h0;
      ds_q       <= 1'b0;
      pc_q       <= 32'h0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      rpc_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      bad_addr_q <= bad_addr_d;
      ds_q       <= ds_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
    end
  end

  assign exc_code    = code_q;
  assign bad_addr    = bad_addr_q;
  assign delay_slot  = ds_q;
  assign exc_pc      = pc_q;
  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: timestamp-based behavioural model, directed corner cases, random traffic.
module tb_exc_ctrl;

  localparam int          FC  = 2;
  localparam logic [31:0] VEC = 32'hBFC00380;

  localparam logic [4:0] C_INT  = 5'h00;
  localparam logic [4:0] C_ADEL = 5'h04;
  localparam logic [4:0] C_ADES = 5'h05;
  localparam logic [4:0] C_SYS  = 5'h08;
  localparam logic [4:0] C_BP   = 5'h09;
  localparam logic [4:0] C_RI   = 5'h0a;
  localparam logic [4:0] C_OV   = 5'h0c;
  localparam logic [4:0] C_ERET = 5'h0e;
  localparam logic [4:0] C_NONE = 5'h1f;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, stall, mem_ds;
  logic [31:0] mem_pc, mem_addr;
  logic        f_adel, f_ri, f_ov, f_sys, f_bp, f_eret, f_ld_adel, f_st_ades;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic [4:0]  exc_code;
  logic [31:0] bad_addr, exc_pc, redirect_pc;
  logic        delay_slot, flush, redirect;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  // Model: remembers the edge at which the last exception was taken.
  int          edge_n = 0;
  int          take_edge;
  logic [4:0]  m_code;
  logic [31:0] m_bad, m_pc, m_rpc;
  logic        m_ds, m_flush, m_redir;

  exc_ctrl #(.FLUSH_CYCLES(FC), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .stall(stall),
    .mem_pc(mem_pc), .mem_ds(mem_ds), .mem_addr(mem_addr),
    .f_adel(f_adel), .f_ri(f_ri), .f_ov(f_ov), .f_sys(f_sys), .f_bp(f_bp),
    .f_eret(f_eret), .f_ld_adel(f_ld_adel), .f_st_ades(f_st_ades),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .exc_code(exc_code), .bad_addr(bad_addr), .delay_slot(delay_slot),
    .exc_pc(exc_pc), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    take_edge = -100;
    m_code = C_NONE; m_bad = 0; m_pc = 0; m_rpc = 0;
    m_ds = 0; m_flush = 0; m_redir = 0;
  endtask

  // Evaluate what the outputs must be after the coming edge, from the current inputs.
  task automatic model_edge();
    logic [8:0] src;
    logic [4:0] codes[9];
    logic       ip;
    codes = '{C_INT, C_ADEL, C_RI, C_OV, C_SYS, C_BP, C_ERET, C_ADEL, C_ADES};
    if (rst) begin
      model_reset();
      return;
    end
    ip  = !cp0_status[1] && cp0_status[0] && ((cp0_status[15:8] & cp0_cause[15:8]) != 0);
    src = {ip, f_adel, f_ri, f_ov, f_sys, f_bp, f_eret, f_ld_adel, f_st_ades};
    m_code  = C_NONE;
    m_redir = 1'b0;
    if (edge_n >= take_edge + FC + 1 && mem_valid && !stall && src != 0) begin
      for (int k = 0; k < 9; k++) begin
        if (src[8-k]) begin
          take_edge = edge_n;
          m_code  = codes[k];
          m_pc    = mem_pc;
          m_ds    = mem_ds;
          m_redir = 1'b1;
          m_rpc   = (k == 6) ? cp0_epc : VEC;
          m_bad   = (k == 1) ? mem_pc : ((k >= 7) ? mem_addr : 32'h0);
          break;
        end
      end
    end
    m_flush = (edge_n >= take_edge) && (edge_n <= take_edge + FC - 1);
  endtask

  task automatic compare_all();
    chk("exc_code",    {27'h0, exc_code}, {27'h0, m_code});
    chk("bad_addr",    bad_addr, m_bad);
    chk("delay_slot",  {31'h0, delay_slot}, {31'h0, m_ds});
    chk("exc_pc",      exc_pc, m_pc);
    chk("flush",       {31'h0, flush}, {31'h0, m_flush});
    chk("redirect",    {31'h0, redirect}, {31'h0, m_redir});
    chk("redirect_pc", redirect_pc, m_rpc);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    edge_n++;
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    mem_valid = 0; stall = 0; mem_ds = 0; mem_pc = 0; mem_addr = 0;
    f_adel = 0; f_ri = 0; f_ov = 0; f_sys = 0; f_bp = 0; f_eret = 0;
    f_ld_adel = 0; f_st_ades = 0;
    cp0_status = 0; cp0_cause = 0; cp0_epc = 0;
  endtask

  task automatic clear_flags();
    f_adel = 0; f_ri = 0; f_ov = 0; f_sys = 0; f_bp = 0; f_eret = 0;
    f_ld_adel = 0; f_st_ades = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_code"},  {27'h0, exc_code}, {27'h0, C_NONE});
    chk({tag, "_bad"},   bad_addr, 32'h0);
    chk({tag, "_ds"},    {31'h0, delay_slot}, 32'h0);
    chk({tag, "_pc"},    exc_pc, 32'h0);
    chk({tag, "_flush"}, {31'h0, flush}, 32'h0);
    chk({tag, "_redir"}, {31'h0, redirect}, 32'h0);
    chk({tag, "_rpc"},   redirect_pc, 32'h0);
  endtask

  task automatic idle_cycles(input int n);
    clear_flags();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    model_reset();
    #2;
    check_reset_values("por");
    @(posedge clk); #1;
    edge_n++;
    rst = 1'b0;

    // f_ov in delay slot
    mem_valid = 1; mem_pc = 32'h80001000; mem_ds = 1; f_ov = 1;
    cycle();
    chk("ov_code", {27'h0, exc_code}, {27'h0, C_OV});
    chk("ov_pc", exc_pc, 32'h80001000);
    chk("ov_ds", {31'h0, delay_slot}, 32'h1);
    chk("ov_redir", {31'h0, redirect}, 32'h1);
    chk("ov_rpc", redirect_pc, 32'hBFC00380);
    clear_flags(); mem_ds = 0;
    cycle();
    chk("ov_code_1cyc", {27'h0, exc_code}, {27'h0, C_NONE});
    chk("ov_flush2", {31'h0, flush}, 32'h1);
    chk("ov_redir_1cyc", {31'h0, redirect}, 32'h0);
    cycle();
    chk("ov_flush_end", {31'h0, flush}, 32'h0);

    // load address error
    mem_pc = 32'h80000100; mem_addr = 32'h80000003; f_ld_adel = 1;
    cycle();
    chk("ld_code", {27'h0, exc_code}, {27'h0, C_ADEL});
    chk("ld_bad", bad_addr, 32'h80000003);
    idle_cycles(2);

    // fetch adel beats load adel, bad_addr from pc
    mem_pc = 32'h80000002; mem_addr = 32'h80000003; f_adel = 1; f_ld_adel = 1;
    cycle();
    chk("adel_code", {27'h0, exc_code}, {27'h0, C_ADEL});
    chk("adel_bad", bad_addr, 32'h80000002);
    idle_cycles(2);

    // eret, then eret with interrupt pending
    mem_pc = 32'h80000200; cp0_epc = 32'h80002000; f_eret = 1;
    cycle();
    chk("eret_code", {27'h0, exc_code}, {27'h0, C_ERET});
    chk("eret_rpc", redirect_pc, 32'h80002000);
    idle_cycles(2);
    f_eret = 1; cp0_status = 32'h0000FF01; cp0_cause = 32'h00000400;
    cycle();
    chk("int_code", {27'h0, exc_code}, {27'h0, C_INT});
    chk("int_rpc", redirect_pc, 32'hBFC00380);
    chk("int_pc", exc_pc, 32'h80000200);
    idle_cycles(2);

    // interrupt pending with mem_valid low: nothing taken
    mem_valid = 0;
    cycle();
    chk("noval_code", {27'h0, exc_code}, {27'h0, C_NONE});
    chk("noval_flush", {31'h0, flush}, 32'h0);
    cp0_status = 0; cp0_cause = 0; mem_valid = 1;

    // syscall held off by stall, later flags in FLUSH ignored
    f_sys = 1; stall = 1; mem_pc = 32'h80000300;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_code", {27'h0, exc_code}, {27'h0, C_NONE});
      chk("stall_flush", {31'h0, flush}, 32'h0);
    end
    stall = 0;
    cycle();
    chk("sys_code", {27'h0, exc_code}, {27'h0, C_SYS});
    f_sys = 0; f_ri = 1; f_bp = 1;
    cycle();
    chk("sq_code1", {27'h0, exc_code}, {27'h0, C_NONE});
    cycle();
    chk("sq_code2", {27'h0, exc_code}, {27'h0, C_NONE});
    chk("sq_redir", {31'h0, redirect}, 32'h0);
    idle_cycles(1);

    // async reset mid-FLUSH
    f_bp = 1; mem_pc = 32'h80000400;
    cycle();
    chk("bp_code", {27'h0, exc_code}, {27'h0, C_BP});
    chk("bp_flush", {31'h0, flush}, 32'h1);
    rst = 1'b1;
    #1;
    check_reset_values("arst");
    model_reset();
    #1;
    rst = 1'b0;
    idle_cycles(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      mem_valid  = ($urandom_range(0, 7) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      mem_ds     = 1'($urandom_range(0, 1));
      mem_pc     = $urandom;
      mem_addr   = $urandom;
      cp0_epc    = $urandom;
      f_adel     = ($urandom_range(0, 15) == 0);
      f_ri       = ($urandom_range(0, 15) == 0);
      f_ov       = ($urandom_range(0, 15) == 0);
      f_sys      = ($urandom_range(0, 15) == 0);
      f_bp       = ($urandom_range(0, 15) == 0);
      f_eret     = ($urandom_range(0, 15) == 0);
      f_ld_adel  = ($urandom_range(0, 15) == 0);
      f_st_ades  = ($urandom_range(0, 15) == 0);
      cp0_status = {16'h0, 8'($urandom_range(0, 255)), 6'h0, 2'($urandom_range(0, 3))};
      cp0_cause  = {16'h0, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h0, 8'h0};
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
